// File: rtl/isp_raw_src_gen.sv
// Raw Bayer test-pattern video source. Generates vsync, active lines and
// blanking on pclk from the same width/height programming the ISP consumes,
// and fills each active line with one of four test patterns.
module isp_raw_src_gen #(
  parameter int unsigned VSYNC_W = 4,
  parameter int unsigned VBACK   = 8,
  parameter int unsigned HBLANK  = 16,
  parameter int unsigned VFRONT  = 8
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [7:0]  flat_value,
  input  logic [31:0] isp_width,
  input  logic [31:0] isp_height,
  output logic        out_vsync,
  output logic        out_href,
  output logic [7:0]  out_raw,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_HBLANK,
    S_VFRONT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;     // cycles spent in current state; column in ACTIVE
  logic [15:0] row_q, row_d;
  logic [15:0] w_q, w_d;
  logic [15:0] h_q, h_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  raw_q, raw_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic        start_ok;
  logic [7:0]  pix;

  // Only the low 16 bits of the geometry words are meaningful.
  logic unused_hi;
  assign unused_hi = ^{isp_width[31:16], isp_height[31:16]};

  assign start_ok = enable && (isp_width[15:0] >= 16'd2) && (isp_height[15:0] >= 16'd2);

  // State, counters and latched frame configuration.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      pat_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      w_q     <= w_d;
      h_q     <= h_d;
      pat_q   <= pat_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state sequencing through sync, back porch, lines and front porch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    row_d   = row_q;
    w_d     = w_q;
    h_d     = h_q;
    pat_d   = pat_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        row_d = '0;
        if (start_ok) begin
          state_d = S_VSYNC;
          w_d     = isp_width[15:0];
          h_d     = isp_height[15:0];
          pat_d   = pattern_sel;
        end
      end
      S_VSYNC: begin
        if (cnt_q == 16'(VSYNC_W - 1)) begin
          state_d = S_VBACK;
          cnt_d   = '0;
        end
      end
      S_VBACK: begin
        if (cnt_q == 16'(VBACK - 1)) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          row_d   = '0;
        end
      end
      S_ACTIVE: begin
        if (cnt_q == w_q - 16'd1) begin
          state_d = S_HBLANK;
          cnt_d   = '0;
        end
      end
      S_HBLANK: begin
        if (cnt_q == 16'(HBLANK - 1)) begin
          cnt_d = '0;
          if (row_q == h_q - 16'd1) begin
            state_d = S_VFRONT;
          end else begin
            state_d = S_ACTIVE;
            row_d   = row_q + 16'd1;
          end
        end
      end
      S_VFRONT: begin
        if (cnt_q == 16'(VFRONT - 1)) begin
          cnt_d = '0;
          row_d = '0;
          if (start_ok) begin
            state_d = S_VSYNC;
            w_d     = isp_width[15:0];
            h_d     = isp_height[15:0];
            pat_d   = pattern_sel;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pixel value for the upcoming cycle, from next column/row and latched pattern.
  always_comb begin
    pix = '0;
    unique case (pat_d)
      2'd0: pix = 8'(cnt_d + row_d);
      2'd1: begin
        if (!row_d[0] && !cnt_d[0])     pix = 8'hF0;
        else if (row_d[0] && cnt_d[0])  pix = 8'h10;
        else                            pix = 8'h80;
      end
      2'd2: pix = flat_value;
      2'd3: pix = (cnt_d[3] ^ row_d[3]) ? 8'hFF : 8'h00;
      default: pix = '0;
    endcase
  end

  // Outputs decoded from next state so they are registered yet aligned with the state.
  always_comb begin
    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_ACTIVE);
    raw_d   = href_d ? pix : '0;
    done_d  = (state_d == S_VFRONT) && (cnt_d == 16'(VFRONT - 1));
    busy_d  = (state_d != S_IDLE);
    fcnt_d  = fcnt_q + {15'd0, done_d};
  end

  // Output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      raw_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      href_q  <= href_d;
      raw_q   <= raw_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign out_vsync  = vsync_q;
  assign out_href   = href_q;
  assign out_raw    = raw_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;
  assign busy       = busy_q;

endmodule
